spsram_axi_slave: RTL and testbench

- AXI3-style slave, single clock, fronting one internal single-port synchronous SRAM array with byte write enables.
- Serves as a simulation or on-chip RAM target behind the system interconnect.
- Performs one read or one write access per memory cycle.
- Executes write bursts and read bursts one at a time, under arbitration.

---
 rtl/spsram_axi_slave.sv | 192 +++++++++++++++++++
 tb/tb_spsram_axi_slave.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spsram_axi_slave.sv
// AXI3 slave in front of a single-port synchronous SRAM with byte write enables.
// Optional macro SPSRAM_AXI_RANGE_CHECK_EN: out-of-range beats are dropped and answered with SLVERR.
module spsram_axi_slave #(
  parameter int                  BW_ADDR    = 32,
  parameter int                  BW_DATA    = 32,
  parameter int                  BW_AXI_TID = 16,
  parameter logic [BW_ADDR-1:0]  BASEADDR   = '0,
  parameter int unsigned         CELL_SIZE  = 65536
) (
  input  logic                    clk,
  input  logic                    rstnn,
  input  logic                    enable,
  input  logic [BW_AXI_TID-1:0]   rxawid,
  input  logic [BW_ADDR-1:0]      rxawaddr,
  input  logic [3:0]              rxawlen,
  input  logic [2:0]              rxawsize,
  input  logic [1:0]              rxawburst,
  input  logic                    rxawvalid,
  output logic                    rxawready,
  input  logic [BW_AXI_TID-1:0]   rxwid,
  input  logic [BW_DATA-1:0]      rxwdata,
  input  logic [BW_DATA/8-1:0]    rxwstrb,
  input  logic                    rxwlast,
  input  logic                    rxwvalid,
  output logic                    rxwready,
  output logic [BW_AXI_TID-1:0]   rxbid,
  output logic [1:0]              rxbresp,
  output logic                    rxbvalid,
  input  logic                    rxbready,
  input  logic [BW_AXI_TID-1:0]   rxarid,
  input  logic [BW_ADDR-1:0]      rxaraddr,
  input  logic [3:0]              rxarlen,
  input  logic [2:0]              rxarsize,
  input  logic [1:0]              rxarburst,
  input  logic                    rxarvalid,
  output logic                    rxarready,
  output logic [BW_AXI_TID-1:0]   rxrid,
  output logic [BW_DATA-1:0]      rxrdata,
  output logic [1:0]              rxrresp,
  output logic                    rxrlast,
  output logic                    rxrvalid,
  input  logic                    rxrready
);

  localparam int          NB     = BW_DATA / 8;
  localparam int          NB_LOG = $clog2(NB);
  localparam int unsigned DEPTH  = (CELL_SIZE + NB - 1) / NB;
  localparam int          IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RADDR, RDATA} state_t;

  state_t                 state_q, state_d;
  logic [BW_AXI_TID-1:0]  id_q;
  logic [BW_ADDR-1:0]     addr_q, addr_nxt, step, wrap_mask;
  logic [3:0]             len_q, cnt_q;
  logic [2:0]             size_q;
  logic [1:0]             burst_q;
  logic                   berr_q, last_rd_q;
  logic [BW_DATA-1:0]     rdata_q;
  logic [1:0]             rresp_q;
  logic                   aw_acc, ar_acc, w_hs, r_hs, r_last;
  logic [BW_ADDR-1:0]     off, word;
  logic [IW-1:0]          idx;
  logic                   in_range;
  logic [BW_DATA-1:0]     mem [DEPTH];

  logic unused_ok;
  assign unused_ok = ^rxwid;

  assign off  = addr_q - BASEADDR;
  assign word = off >> NB_LOG;
  assign idx  = IW'(word % BW_ADDR'(DEPTH));

`ifdef SPSRAM_AXI_RANGE_CHECK_EN
  assign in_range = (addr_q >= BASEADDR) && ({1'b0, off} < (BW_ADDR+1)'(CELL_SIZE));
`else
  assign in_range = 1'b1;
`endif

  // WRAP keeps the upper bits of the aligned window and lets only the low bits roll over.
  always_comb begin
    step      = BW_ADDR'(1) << size_q;
    wrap_mask = ((BW_ADDR'(len_q) + BW_ADDR'(1)) << size_q) - BW_ADDR'(1);
    addr_nxt  = addr_q + step;
    case (burst_q)
      2'b00:   addr_nxt = addr_q;
      2'b10:   addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default: addr_nxt = addr_q + step;
    endcase
  end

  assign r_last = (cnt_q == len_q);
  assign w_hs   = (state_q == WDATA) && rxwvalid;
  assign r_hs   = (state_q == RDATA) && rxrready;

  // Round-robin: a pending write wins unless the previous grant was also a write.
  always_comb begin
    state_d = state_q;
    aw_acc  = 1'b0;
    ar_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !rstnn) begin
          if (rxawvalid && (!rxarvalid || last_rd_q)) begin
            aw_acc  = 1'b1;
            state_d = WDATA;
          end else if (rxarvalid) begin
            ar_acc  = 1'b1;
            state_d = RADDR;
          end
        end
      end
      WDATA:   if (rxwvalid && rxwlast) state_d = WRESP;
      WRESP:   if (rxbready) state_d = IDLE;
      RADDR:   state_d = RDATA;
      RDATA:   if (rxrready) state_d = r_last ? IDLE : RADDR;
      default: state_d = IDLE;
    endcase
  end

  assign rxawready = aw_acc;
  assign rxarready = ar_acc;
  assign rxwready  = (state_q == WDATA);
  assign rxbvalid  = (state_q == WRESP);
  assign rxrvalid  = (state_q == RDATA);
  assign rxrlast   = (state_q == RDATA) && r_last;
  assign rxbid     = id_q;
  assign rxrid     = id_q;
  assign rxbresp   = berr_q ? RESP_SLVERR : RESP_OKAY;
  assign rxrdata   = rdata_q;
  assign rxrresp   = rresp_q;

  always_ff @(posedge clk or posedge rstnn) begin
    if (rstnn) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      berr_q    <= 1'b0;
      last_rd_q <= 1'b1;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      if (aw_acc) begin
        id_q      <= rxawid;
        addr_q    <= rxawaddr;
        len_q     <= rxawlen;
        size_q    <= rxawsize;
        burst_q   <= rxawburst;
        berr_q    <= 1'b0;
        last_rd_q <= 1'b0;
      end
      if (ar_acc) begin
        id_q      <= rxarid;
        addr_q    <= rxaraddr;
        len_q     <= rxarlen;
        size_q    <= rxarsize;
        burst_q   <= rxarburst;
        cnt_q     <= '0;
        last_rd_q <= 1'b1;
      end
      if (w_hs) begin
        addr_q <= addr_nxt;
        if (!in_range) berr_q <= 1'b1;
      end
      if (state_q == RADDR) begin
        rdata_q <= in_range ? mem[idx] : '0;
        rresp_q <= in_range ? RESP_OKAY : RESP_SLVERR;
      end
      if (r_hs && !r_last) begin
        addr_q <= addr_nxt;
        cnt_q  <= cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && in_range) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (rxwstrb[k]) mem[idx][8*k +: 8] <= rxwdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_spsram_axi_slave.sv
// Self-checking bench for spsram_axi_slave: vector table, directed corner cases and
// randomized bursts checked against a flat byte-addressed reference memory.
module tb_spsram_axi_slave;

  localparam int          TMO       = 200;
  localparam int unsigned BASEADDR  = 32'h2200;
  localparam int unsigned CELL_SIZE = 4096;
  localparam int unsigned DEPTH     = CELL_SIZE / 4;

  logic        clk = 1'b0, rstnn = 1'b1, enable = 1'b1;
  logic [15:0] rxawid = '0, rxwid = '0, rxarid = '0, rxbid, rxrid;
  logic [31:0] rxawaddr = '0, rxaraddr = '0, rxwdata = '0, rxrdata;
  logic [3:0]  rxawlen = '0, rxarlen = '0, rxwstrb = '0;
  logic [2:0]  rxawsize = '0, rxarsize = '0;
  logic [1:0]  rxawburst = '0, rxarburst = '0, rxbresp, rxrresp;
  logic        rxawvalid = 1'b0, rxawready, rxwlast = 1'b0, rxwvalid = 1'b0, rxwready;
  logic        rxbvalid, rxbready = 1'b0, rxarvalid = 1'b0, rxarready;
  logic        rxrlast, rxrvalid, rxrready = 1'b0;

  always #5 clk = ~clk;

  spsram_axi_slave #(
    .BW_ADDR(32), .BW_DATA(32), .BW_AXI_TID(16),
    .BASEADDR(32'(BASEADDR)), .CELL_SIZE(CELL_SIZE)
  ) dut (
    .clk(clk), .rstnn(rstnn), .enable(enable),
    .rxawid(rxawid), .rxawaddr(rxawaddr), .rxawlen(rxawlen), .rxawsize(rxawsize),
    .rxawburst(rxawburst), .rxawvalid(rxawvalid), .rxawready(rxawready),
    .rxwid(rxwid), .rxwdata(rxwdata), .rxwstrb(rxwstrb), .rxwlast(rxwlast),
    .rxwvalid(rxwvalid), .rxwready(rxwready),
    .rxbid(rxbid), .rxbresp(rxbresp), .rxbvalid(rxbvalid), .rxbready(rxbready),
    .rxarid(rxarid), .rxaraddr(rxaraddr), .rxarlen(rxarlen), .rxarsize(rxarsize),
    .rxarburst(rxarburst), .rxarvalid(rxarvalid), .rxarready(rxarready),
    .rxrid(rxrid), .rxrdata(rxrdata), .rxrresp(rxrresp), .rxrlast(rxrlast),
    .rxrvalid(rxrvalid), .rxrready(rxrready)
  );

  int          checks = 0, errors = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no handshake within %0d cycles, required one", name, TMO);
  endtask

  // Reference model: address arithmetic straight from the burst rules.
  function automatic bit in_rng(input logic [31:0] a);
`ifdef SPSRAM_AXI_RANGE_CHECK_EN
    return (a >= BASEADDR) && ((a - BASEADDR) < CELL_SIZE);
`else
    return (a == a);
`endif
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASEADDR;
    return (o >> 2) % DEPTH;
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int unsigned len,
                                            input int unsigned size, input int unsigned burst,
                                            input int unsigned i);
    logic [31:0] step, win, lo;
    step = 32'd1 << size;
    win  = (len + 1) * step;
    lo   = a - (a % win);
    case (burst)
      0:       return a;
      2:       return lo + ((a - lo + i * step) % win);
      default: return a + i * step;
    endcase
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_rng(a))
      for (int k = 0; k < 4; k++) if (s[k]) model[widx(a)][8*k +: 8] = d[8*k +: 8];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return in_rng(a) ? model[widx(a)] : 32'h0;
  endfunction

  task automatic send_aw(input logic [15:0] id, input logic [31:0] a, input int unsigned len,
                         input int unsigned size, input int unsigned burst, output bit ok);
    int n = 0;
    @(negedge clk);
    rxawid = id; rxawaddr = a; rxawlen = 4'(len); rxawsize = 3'(size); rxawburst = 2'(burst);
    rxawvalid = 1'b1;
    #1;
    while (!rxawready && n < TMO) begin @(negedge clk); #1; n++; end
    ok = rxawready;
    if (!ok) tmo("awready");
    @(posedge clk);
    #1 rxawvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] a, input int unsigned len, input int unsigned size,
                        input int unsigned burst, input int unsigned nbeats, input bit rnd,
                        output bit ok);
    ok = 1'b1;
    for (int unsigned i = 0; i < nbeats && ok; i++) begin
      int n = 0;
      @(negedge clk);
      if (rnd) repeat ($urandom_range(0, 1)) @(negedge clk);
      rxwid = 16'hBEEF; rxwdata = wd[i]; rxwstrb = ws[i]; rxwlast = (i == len); rxwvalid = 1'b1;
      #1;
      while (!rxwready && n < TMO) begin @(negedge clk); #1; n++; end
      ok = rxwready;
      if (!ok) tmo("wready");
      @(posedge clk);
      #1 rxwvalid = 1'b0;
      rxwlast = 1'b0;
      if (ok) model_write(beat_addr(a, len, size, burst, i), wd[i], ws[i]);
    end
  endtask

  task automatic get_b(input logic [15:0] id, input logic [1:0] resp, input int unsigned dly);
    int n = 0;
    @(negedge clk);
    repeat (dly) @(negedge clk);
    #1;
    while (!rxbvalid && n < TMO) begin @(negedge clk); #1; n++; end
    if (!rxbvalid) begin tmo("bvalid"); return; end
    check("bid", rxbid, id);
    check("bresp", rxbresp, resp);
    rxbready = 1'b1;
    @(posedge clk);
    #1 rxbready = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] id, input logic [31:0] a, input int unsigned len,
                          input int unsigned size, input int unsigned burst, input bit rnd);
    bit ok;
    logic [1:0] resp = 2'b00;
    for (int unsigned i = 0; i <= len; i++) if (!in_rng(beat_addr(a, len, size, burst, i))) resp = 2'b10;
    send_aw(id, a, len, size, burst, ok);
    if (!ok) return;
    send_w(a, len, size, burst, len + 1, rnd, ok);
    if (!ok) return;
    get_b(id, resp, rnd ? $urandom_range(0, 2) : 0);
  endtask

  task automatic send_ar(input logic [15:0] id, input logic [31:0] a, input int unsigned len,
                         input int unsigned size, input int unsigned burst, output bit ok,
                         output longint unsigned t);
    int n = 0;
    @(negedge clk);
    rxarid = id; rxaraddr = a; rxarlen = 4'(len); rxarsize = 3'(size); rxarburst = 2'(burst);
    rxarvalid = 1'b1;
    #1;
    while (!rxarready && n < TMO) begin @(negedge clk); #1; n++; end
    ok = rxarready;
    if (!ok) tmo("arready");
    @(posedge clk);
    t = $time;
    #1 rxarvalid = 1'b0;
  endtask

  // Every beat must appear exactly 2 cycles after the AR accept or the previous R handshake.
  task automatic get_r(input logic [15:0] id, input logic [31:0] a, input int unsigned len,
                       input int unsigned size, input int unsigned burst, input int hold_beat,
                       input int unsigned hold_cycles, input bit rnd, input longint unsigned t_acc,
                       output logic [31:0] rd_last);
    longint unsigned t_prev = t_acc;
    rd_last = '0;
    for (int unsigned i = 0; i <= len; i++) begin
      logic [31:0] ba, exp;
      int n = 0;
      ba  = beat_addr(a, len, size, burst, i);
      exp = model_read(ba);
      @(negedge clk);
      #1;
      while (!rxrvalid && n < TMO) begin @(negedge clk); #1; n++; end
      if (!rxrvalid) begin tmo("rvalid"); return; end
      check($sformatf("r_latency[%0d]", i), ($time - t_prev + 4) / 10, 2);
      check($sformatf("rdata[%0d]", i), rxrdata, exp);
      check($sformatf("rlast[%0d]", i), rxrlast, i == len);
      check($sformatf("rid[%0d]", i), rxrid, id);
      check($sformatf("rresp[%0d]", i), rxrresp, in_rng(ba) ? 2'b00 : 2'b10);
      rd_last = rxrdata;
      if (int'(i) == hold_beat) begin
        for (int unsigned c = 0; c < hold_cycles; c++) begin
          @(negedge clk);
          #1;
          check("hold_rvalid", rxrvalid, 1);
          check("hold_rdata", rxrdata, exp);
          check("hold_rlast", rxrlast, i == len);
        end
      end else if (rnd) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      rxrready = 1'b1;
      @(posedge clk);
      t_prev = $time;
      #1 rxrready = 1'b0;
    end
  endtask

  task automatic do_read(input logic [15:0] id, input logic [31:0] a, input int unsigned len,
                         input int unsigned size, input int unsigned burst, input int hold_beat,
                         input int unsigned hold_cycles, input bit rnd, output logic [31:0] rd);
    bit ok;
    longint unsigned t;
    rd = '0;
    send_ar(id, a, len, size, burst, ok, t);
    if (ok) get_r(id, a, len, size, burst, hold_beat, hold_cycles, rnd, t, rd);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] off;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [15:0] id;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          ok;
    longint unsigned t;
    logic [31:0] rd;

    vt[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 16'h5, 32'h0};
    vt[1] = '{1'b0, 32'h10, 32'h0,        4'h0, 16'h3, 32'hDEADBEEF};
    vt[2] = '{1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 16'h6, 32'h0};
    vt[3] = '{1'b1, 32'h20, 32'h00000000, 4'h5, 16'h7, 32'h0};
    vt[4] = '{1'b0, 32'h20, 32'h0,        4'h0, 16'h8, 32'hFF00FF00};
    vt[5] = '{1'b1, 32'h24, 32'hA5A5A5A5, 4'hF, 16'h9, 32'h0};
    vt[6] = '{1'b1, 32'h24, 32'h0000003C, 4'h1, 16'hA, 32'h0};
    vt[7] = '{1'b1, 32'h24, 32'h77000000, 4'h8, 16'hB, 32'h0};
    vt[8] = '{1'b0, 32'h24, 32'h0,        4'h0, 16'hC, 32'h77A5A53C};
    vt[9] = '{1'b0, 32'h10, 32'h0,        4'h0, 16'hD, 32'hDEADBEEF};

    // Reset state, with a request pending while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rxawvalid = 1'b1;
    #1;
    check("rst_awready", rxawready, 0);
    check("rst_wready", rxwready, 0);
    check("rst_bvalid", rxbvalid, 0);
    check("rst_rvalid", rxrvalid, 0);
    check("rst_ids", {rxbid, rxrid}, 0);
    check("rst_rdata", rxrdata, 0);
    check("rst_resps", {rxbresp, rxrresp}, 0);
    rxawvalid = 1'b0;
    @(negedge clk);
    rstnn = 1'b0;

    // First contention after reset: write wins, read waits for the B handshake.
    @(negedge clk);
    rxawid = 16'h0A; rxawaddr = BASEADDR + 32'h40; rxawlen = 0; rxawsize = 2; rxawburst = 1;
    rxarid = 16'h0B; rxaraddr = BASEADDR + 32'h40; rxarlen = 0; rxarsize = 2; rxarburst = 1;
    rxawvalid = 1'b1; rxarvalid = 1'b1;
    #1;
    check("contend1_awready", rxawready, 1);
    check("contend1_arready", rxarready, 0);
    @(posedge clk);
    #1 rxawvalid = 1'b0;
    @(negedge clk);
    #1 check("contend1_ar_wait", rxarready, 0);
    wd[0] = 32'h13579BDF; ws[0] = 4'hF;
    send_w(BASEADDR + 32'h40, 0, 2, 1, 1, 0, ok);
    get_b(16'h0A, 2'b00, 0);
    send_ar(16'h0B, BASEADDR + 32'h40, 0, 2, 1, ok, t);
    if (ok) get_r(16'h0B, BASEADDR + 32'h40, 0, 2, 1, -1, 0, 0, t, rd);
    check("contend1_rdata", rd, 32'h13579BDF);

    // After a lone write, the next contention goes to the read.
    wd[0] = 32'h2468ACE0; ws[0] = 4'hF;
    do_write(16'h11, BASEADDR + 32'h44, 0, 2, 1, 0);
    @(negedge clk);
    rxawid = 16'h12; rxawaddr = BASEADDR + 32'h48; rxawlen = 0; rxawsize = 2; rxawburst = 1;
    rxarid = 16'h13; rxaraddr = BASEADDR + 32'h44; rxarlen = 0; rxarsize = 2; rxarburst = 1;
    rxawvalid = 1'b1; rxarvalid = 1'b1;
    #1;
    check("contend2_arready", rxarready, 1);
    check("contend2_awready", rxawready, 0);
    @(posedge clk);
    t = $time;
    #1 rxarvalid = 1'b0;
    get_r(16'h13, BASEADDR + 32'h44, 0, 2, 1, -1, 0, 0, t, rd);
    check("contend2_rdata", rd, 32'h2468ACE0);
    wd[0] = 32'h0BADCAFE; ws[0] = 4'hF;
    send_w(BASEADDR + 32'h48, 0, 2, 1, 1, 0, ok);
    rxawvalid = 1'b0;
    get_b(16'h12, 2'b00, 0);

    // Fill the whole array so every later read has a defined expectation.
    for (int b = 0; b < int'(CELL_SIZE / 64); b++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      do_write(16'(b), BASEADDR + 32'(b * 64), 15, 2, 1, 0);
    end

    for (int i = 0; i < 10; i++) begin
      if (vt[i].wr) begin
        wd[0] = vt[i].data; ws[0] = vt[i].strb;
        do_write(vt[i].id, BASEADDR + vt[i].off, 0, 2, 1, 0);
      end else begin
        do_read(vt[i].id, BASEADDR + vt[i].off, 0, 2, 1, -1, 0, 0, rd);
        check($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
      end
    end

    // INCR burst 1..4, read back with 5 cycles of backpressure on the 2nd beat.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(16'h21, BASEADDR + 32'h100, 3, 2, 1, 0);
    do_read(16'h22, BASEADDR + 32'h100, 3, 2, 1, 1, 5, 0, rd);
    check("incr_last_rdata", rd, 32'h4);

    // WRAP burst starting mid-window, checked by an INCR read of the window.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
    do_write(16'h23, BASEADDR + 32'h208, 3, 2, 2, 0);
    do_read(16'h24, BASEADDR + 32'h200, 3, 2, 1, -1, 0, 0, rd);
    check("wrap_rdata_word3", rd, 32'hA1);

    // enable=0 blocks new bursts but lets an accepted burst finish.
    enable = 1'b0;
    @(negedge clk);
    rxawid = 16'h25; rxawaddr = BASEADDR + 32'h50; rxawlen = 0; rxawsize = 2; rxawburst = 1;
    rxawvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin #1 check("disabled_awready", rxawready, 0); @(negedge clk); end
    enable = 1'b1;
    #1 check("enabled_awready", rxawready, 1);
    @(posedge clk);
    #1 rxawvalid = 1'b0;
    enable = 1'b0;
    wd[0] = 32'h55AA33CC; ws[0] = 4'hF;
    send_w(BASEADDR + 32'h50, 0, 2, 1, 1, 0, ok);
    get_b(16'h25, 2'b00, 0);
    enable = 1'b1;
    do_read(16'h26, BASEADDR + 32'h50, 0, 2, 1, -1, 0, 0, rd);
    check("enable_rdata", rd, 32'h55AA33CC);

    // One byte past the array: aliases to word 0, or SLVERR with range checking.
    wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
    do_write(16'h27, BASEADDR + CELL_SIZE, 0, 2, 1, 0);
    do_read(16'h28, BASEADDR, 0, 2, 1, -1, 0, 0, rd);
    do_read(16'h29, BASEADDR + CELL_SIZE, 0, 2, 1, -1, 0, 0, rd);
`ifdef SPSRAM_AXI_RANGE_CHECK_EN
    check("oob_rdata", rd, 32'h0);
`else
    check("alias_rdata", rd, 32'hCAFEF00D);
`endif

    // Asynchronous reset mid write burst and mid read burst.
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    send_aw(16'h31, BASEADDR + 32'h300, 3, 2, 1, ok);
    send_w(BASEADDR + 32'h300, 3, 2, 1, 2, 0, ok);
    @(negedge clk);
    #1 check("rst_mid_pre_wready", rxwready, 1);
    #1 rstnn = 1'b1;
    #1;
    check("rst_mid_wready", rxwready, 0);
    check("rst_mid_bvalid", rxbvalid, 0);
    @(negedge clk);
    rstnn = 1'b0;
    send_ar(16'h32, BASEADDR + 32'h300, 3, 2, 1, ok, t);
    @(negedge clk);
    @(negedge clk);
    #1 check("rst_mid_pre_rvalid", rxrvalid, 1);
    #1 rstnn = 1'b1;
    #1;
    check("rst_mid_rvalid", rxrvalid, 0);
    check("rst_mid_rdata", rxrdata, 0);
    @(negedge clk);
    rstnn = 1'b0;
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(16'h33, BASEADDR + 32'h300, 3, 2, 1, 0);
    do_read(16'h34, BASEADDR + 32'h300, 3, 2, 1, -1, 0, 0, rd);
    check("post_rst_rdata", rd, wd[3]);

    // Randomized bursts of every type and size, checked against the model.
    for (int n = 0; n < 60; n++) begin
      int unsigned burst, size, len, o;
      logic [31:0] a;
      burst = $urandom_range(0, 3);
      size  = $urandom_range(0, 2);
      len   = (burst == 2) ? (32'd1 << $urandom_range(1, 4)) - 1 : $urandom_range(0, 15);
      o     = $urandom_range(0, CELL_SIZE + 255);
      a     = BASEADDR + (o & ~((32'd1 << size) - 1));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        do_write(16'($urandom), a, len, size, burst, 1);
      end else begin
        do_read(16'($urandom), a, len, size, burst, -1, 0, 1, rd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
